// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array job sequencer.
package systolic_pkg;

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned PREC_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_COLLECT,
        ST_FINISH
    } state_t;

    // PE index width, never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n_pe);
        return (n_pe > 1) ? $clog2(n_pe) : 1;
    endfunction

endpackage

// File: rtl/systolic_result_drain.sv
// Result snapshot and valid/ready serializer for systolic_ctrl.
// Captures all N*N accumulators/exponents on one edge, then emits them
// in index order; outputs are muxed from registers so they hold during stalls.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int unsigned N         = 2,
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            capture,
    input  logic [N*N*ACC_WIDTH-1:0]        arr_acc,
    input  logic [N*N*EXP_W-1:0]            arr_exp,
    input  logic                            res_ready,
    output logic                            res_valid,
    output logic [ACC_WIDTH-1:0]            res_data,
    output logic [EXP_W-1:0]                res_exp,
    output logic [idx_width(N*N)-1:0]       res_idx,
    output logic                            last_xfer
);

    localparam int unsigned NPE  = N * N;
    localparam int unsigned IDXW = idx_width(NPE);

    logic [ACC_WIDTH-1:0] snap_acc [NPE];
    logic [EXP_W-1:0]     snap_exp [NPE];

    assign res_data  = snap_acc[res_idx];
    assign res_exp   = snap_exp[res_idx];
    assign last_xfer = res_valid && res_ready && (res_idx == IDXW'(NPE - 1));

    // Snapshot load on capture, then step the index on each accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NPE; i++) begin
                snap_acc[i] <= '0;
                snap_exp[i] <= '0;
            end
            res_valid <= 1'b0;
            res_idx   <= '0;
        end else if (capture) begin
            for (int unsigned i = 0; i < NPE; i++) begin
                snap_acc[i] <= arr_acc[i*ACC_WIDTH +: ACC_WIDTH];
                snap_exp[i] <= arr_exp[i*EXP_W +: EXP_W];
            end
            res_valid <= 1'b1;
            res_idx   <= '0;
        end else if (res_valid && res_ready) begin
            if (last_xfer) begin
                res_valid <= 1'b0;
            end else begin
                res_idx <= res_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the N x N bit-serial FP-INT systolic array.
// Streams buffer read addresses, waits for the array, then drains results.
// Optional feature macro: SYSTOLIC_CTRL_PERF_EN (busy/stall performance counters).
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N             = 2,
    parameter int unsigned ACC_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned DRAIN_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         k_len,
    input  logic [PREC_W-1:0]             precision,
    input  logic [EXP_W-1:0]              exp_set,
    output logic                          busy,
    output logic                          act_rd_en,
    output logic [ADDR_WIDTH-1:0]         act_rd_addr,
    output logic                          w_rd_en,
    output logic [ADDR_WIDTH-1:0]         w_rd_addr,
    output logic                          arr_active,
    output logic [PREC_W-1:0]             arr_precision,
    output logic [EXP_W-1:0]              arr_exp_set,
    input  logic                          arr_done,
    input  logic [N*N*ACC_WIDTH-1:0]      arr_acc,
    input  logic [N*N*EXP_W-1:0]          arr_exp,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACC_WIDTH-1:0]          res_data,
    output logic [EXP_W-1:0]              res_exp,
    output logic [idx_width(N*N)-1:0]     res_idx,
    output logic                          job_done,
    output logic                          err
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]                   perf_busy_cycles,
    output logic [31:0]                   perf_stall_cycles
`endif
);

    localparam int unsigned BEAT_W = 2 * ADDR_WIDTH + 4;
    localparam int unsigned TO_W   = $clog2(DRAIN_TIMEOUT + 1);

    state_t              state;
    logic [BEAT_W-1:0]   beats_req;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   beat_last;
    logic [PREC_W-1:0]   prec_cnt;
    logic [TO_W-1:0]     drain_cnt;
    logic                capture;
    logic                last_xfer;

    assign beats_req = BEAT_W'(k_len) * BEAT_W'(precision);
    assign capture   = (state == ST_DRAIN) && arr_done;

    // Job FSM with address generation, drain timeout and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            act_rd_en     <= 1'b0;
            act_rd_addr   <= '0;
            w_rd_en       <= 1'b0;
            w_rd_addr     <= '0;
            arr_active    <= 1'b0;
            arr_precision <= '0;
            arr_exp_set   <= '0;
            job_done      <= 1'b0;
            err           <= 1'b0;
            beat          <= '0;
            beat_last     <= '0;
            prec_cnt      <= '0;
            drain_cnt     <= '0;
        end else begin
            job_done   <= 1'b0;
            arr_active <= act_rd_en;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        arr_precision <= precision;
                        arr_exp_set   <= exp_set;
                        err           <= 1'b0;
                        beat          <= '0;
                        beat_last     <= beats_req - BEAT_W'(1);
                        prec_cnt      <= '0;
                        drain_cnt     <= '0;
                        act_rd_addr   <= '0;
                        w_rd_addr     <= '0;
                        busy          <= 1'b1;
                        if (k_len == '0 || precision == '0) begin
                            err   <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            act_rd_en <= 1'b1;
                            w_rd_en   <= 1'b1;
                            state     <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (beat == beat_last) begin
                        act_rd_en <= 1'b0;
                        w_rd_en   <= 1'b0;
                        state     <= ST_DRAIN;
                    end else begin
                        beat      <= beat + BEAT_W'(1);
                        w_rd_addr <= ADDR_WIDTH'(beat + BEAT_W'(1));
                        if (prec_cnt == arr_precision - PREC_W'(1)) begin
                            prec_cnt    <= '0;
                            act_rd_addr <= act_rd_addr + ADDR_WIDTH'(1);
                        end else begin
                            prec_cnt <= prec_cnt + PREC_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (arr_done) begin
                        state <= ST_COLLECT;
                    end else if (drain_cnt == TO_W'(DRAIN_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= ST_FINISH;
                    end else begin
                        drain_cnt <= drain_cnt + TO_W'(1);
                    end
                end
                ST_COLLECT: begin
                    if (last_xfer) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    job_done <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    systolic_result_drain #(
        .N         (N),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_drain (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .arr_acc   (arr_acc),
        .arr_exp   (arr_exp),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_exp   (res_exp),
        .res_idx   (res_idx),
        .last_xfer (last_xfer)
    );

`ifdef SYSTOLIC_CTRL_PERF_EN
    // Saturating busy/stall counters, restarted by each accepted job
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (state == ST_IDLE && start) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state != ST_IDLE && perf_busy_cycles != '1) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (state == ST_COLLECT && res_valid && !res_ready && perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl (N=2, ADDR_WIDTH=8, DRAIN_TIMEOUT=255).
module tb_systolic_ctrl;

    localparam int unsigned N   = 2;
    localparam int unsigned NPE = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        k_len;
    logic [3:0]        precision;
    logic [4:0]        exp_set;
    logic              busy;
    logic              act_rd_en;
    logic [7:0]        act_rd_addr;
    logic              w_rd_en;
    logic [7:0]        w_rd_addr;
    logic              arr_active;
    logic [3:0]        arr_precision;
    logic [4:0]        arr_exp_set;
    logic              arr_done;
    logic [NPE*32-1:0] arr_acc;
    logic [NPE*5-1:0]  arr_exp;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_data;
    logic [4:0]        res_exp;
    logic [1:0]        res_idx;
    logic              job_done;
    logic              err;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]       perf_busy_cycles;
    logic [31:0]       perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    systolic_ctrl #(
        .N             (N),
        .ACC_WIDTH     (32),
        .ADDR_WIDTH    (8),
        .DRAIN_TIMEOUT (255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .k_len         (k_len),
        .precision     (precision),
        .exp_set       (exp_set),
        .busy          (busy),
        .act_rd_en     (act_rd_en),
        .act_rd_addr   (act_rd_addr),
        .w_rd_en       (w_rd_en),
        .w_rd_addr     (w_rd_addr),
        .arr_active    (arr_active),
        .arr_precision (arr_precision),
        .arr_exp_set   (arr_exp_set),
        .arr_done      (arr_done),
        .arr_acc       (arr_acc),
        .arr_exp       (arr_exp),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_exp       (res_exp),
        .res_idx       (res_idx),
        .job_done      (job_done),
        .err           (err)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;
    int jd_cnt = 0;
    int xfer_cnt = 0;
    int stall_seen = 0;

    logic [15:0] rd_q [$];   // {act addr, w addr}
    logic [38:0] res_q [$];  // {idx, exp, data}

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] got);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got %0h expected nothing", name, got);
    endtask

    // Monitor: pops expected read beats and results as the DUT presents them
    logic        prev_rst   = 1'b1;
    logic        prev_rd    = 1'b0;
    logic        prev_stall = 1'b0;
    logic [38:0] prev_out   = '0;

    always @(negedge clk) begin
        logic [38:0] cur;
        logic [15:0] e_rd;
        logic [38:0] e_res;
        cur = {res_idx, res_exp, res_data};
        if (!rst && !prev_rst) begin
            chk("arr_active_lag", 64'(arr_active), 64'(prev_rd));
            if (act_rd_en || w_rd_en) begin
                if (rd_q.size() == 0) begin
                    fail_now("rd_unexpected", 64'({act_rd_addr, w_rd_addr}));
                end else begin
                    e_rd = rd_q.pop_front();
                    chk("rd_beat", 64'({act_rd_en, w_rd_en, act_rd_addr, w_rd_addr}),
                        64'({2'b11, e_rd}));
                end
            end
            if (prev_stall) chk("stall_hold", 64'({res_valid, cur}), 64'({1'b1, prev_out}));
            if (res_valid && res_ready) begin
                xfer_cnt++;
                if (res_q.size() == 0) begin
                    fail_now("res_unexpected", 64'(cur));
                end else begin
                    e_res = res_q.pop_front();
                    chk("result", 64'(cur), 64'(e_res));
                end
            end
            if (res_valid && !res_ready) stall_seen++;
            if (job_done) jd_cnt++;
        end
        prev_rst   = rst;
        prev_rd    = act_rd_en;
        prev_stall = res_valid && !res_ready;
        prev_out   = cur;
    end

    task automatic set_array(input logic [31:0] base, input logic [4:0] eb);
        for (int i = 0; i < NPE; i++) begin
            arr_acc[i*32 +: 32] = base + 32'(i) * 32'h1111_0101;
            arr_exp[i*5 +: 5]   = eb + 5'(i);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({busy, act_rd_en, act_rd_addr, w_rd_en, w_rd_addr, arr_active,
                               arr_precision, arr_exp_set, job_done, err}), 64'(0));
        chk({tag, "_res"}, 64'({res_valid, res_data, res_exp, res_idx}), 64'(0));
    endtask

    // ddelay < 0: arr_done never asserted. stall_mode: res_ready pattern 1,0,0,1.
    task automatic run_job(input int kl, input int pr, input int ddelay,
                           input bit stall_mode, input bit glitch, input logic [4:0] ex);
        int b, cyc, lat, jd0, x0, exp_lat;
        bit exp_err;
        logic [31:0] base;
        b       = kl * pr;
        exp_err = (kl == 0) || (pr == 0) || (ddelay < 0);
        base    = 32'hA000_0000 + 32'(kl * 256 + pr);
        set_array(base, ex);
        for (int i = 0; i < b; i++) rd_q.push_back({8'(i / pr), 8'(i)});
        if (!exp_err)
            for (int i = 0; i < NPE; i++)
                res_q.push_back({2'(i), ex + 5'(i), base + 32'(i) * 32'h1111_0101});
        jd0 = jd_cnt;
        x0  = xfer_cnt;
        stall_seen = 0;
        k_len = 8'(kl); precision = 4'(pr); exp_set = ex; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; k_len = 8'h00; precision = 4'h0; exp_set = ~ex;
        chk("busy_rise", 64'(busy), 64'(1));
        cyc = 0;
        lat = -1;
        while (cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
            if (job_done) begin
                lat = cyc;
                break;
            end
            arr_done  = (ddelay >= 0) && (cyc >= b + ddelay);
            if (ddelay >= 0 && cyc == b + ddelay + 2) set_array(~base, ~ex);
            res_ready = stall_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            start     = glitch && (cyc == 3);
            if (glitch) begin k_len = 8'd1; precision = 4'd1; end
        end
        arr_done = 1'b0; res_ready = 1'b1; start = 1'b0;
        if (b == 0)           exp_lat = 1;
        else if (ddelay < 0)  exp_lat = b + 256;
        else                  exp_lat = b + ddelay + 6;
        if (lat < 0) fail_now("job_done_timeout", 64'(cyc));
        else if (!stall_mode) chk("latency", 64'(lat), 64'(exp_lat));
        repeat (2) begin @(posedge clk); #1; end
        chk("job_done_once", 64'(jd_cnt - jd0), 64'(1));
        chk("xfer_count", 64'(xfer_cnt - x0), exp_err ? 64'(0) : 64'(NPE));
        chk("err", 64'(err), 64'(exp_err));
        chk("latched_cfg", 64'({arr_precision, arr_exp_set}), 64'({4'(pr), ex}));
        chk("rd_q_left", 64'(rd_q.size()), 64'(0));
        chk("res_q_left", 64'(res_q.size()), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
`ifdef SYSTOLIC_CTRL_PERF_EN
        chk("perf_stall", 64'(perf_stall_cycles), 64'(stall_seen));
`endif
    endtask

    initial begin
        int jd0;
        rst = 1'b1; start = 1'b0; k_len = '0; precision = '0; exp_set = '0;
        arr_done = 1'b0; arr_acc = '0; arr_exp = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_job(3, 4, 5, 1'b0, 1'b0, 5'd3);     // basic job
        run_job(3, 4, 5, 1'b1, 1'b0, 5'd7);     // ready stalls
        run_job(2, 3, -1, 1'b0, 1'b0, 5'd9);    // drain timeout
        run_job(0, 4, 0, 1'b0, 1'b0, 5'd1);     // empty job
        run_job(1, 2, 0, 1'b0, 1'b0, 5'd30);    // clears err
        run_job(3, 4, 2, 1'b0, 1'b1, 5'd12);    // start ignored mid-stream

        // Abort mid-stream with reset
        for (int i = 0; i < 12; i++) rd_q.push_back({8'(i / 4), 8'(i)});
        k_len = 8'd3; precision = 4'd4; exp_set = 5'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero_outputs("abort");
        jd0 = jd_cnt;
        repeat (20) begin @(posedge clk); #1; end
        chk("abort_no_job_done", 64'(jd_cnt - jd0), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        rd_q.delete();

        run_job(255, 15, 1, 1'b0, 1'b0, 5'd17); // address wrap, 3825 beats

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
